// File: rtl/vga_patt_pkg.sv
// Shared pattern indices, request/state encodings and the wrap-around step helper
// for the 240p test-pattern sequencer.
package vga_patt_pkg;

    localparam int unsigned PATT_W = 4;

    localparam logic [PATT_W-1:0] PATT_IRE_0   = 4'd0;
    localparam logic [PATT_W-1:0] PATT_IRE_10  = 4'd1;
    localparam logic [PATT_W-1:0] PATT_IRE_20  = 4'd2;
    localparam logic [PATT_W-1:0] PATT_IRE_30  = 4'd3;
    localparam logic [PATT_W-1:0] PATT_IRE_40  = 4'd4;
    localparam logic [PATT_W-1:0] PATT_IRE_50  = 4'd5;
    localparam logic [PATT_W-1:0] PATT_IRE_60  = 4'd6;
    localparam logic [PATT_W-1:0] PATT_IRE_70  = 4'd7;
    localparam logic [PATT_W-1:0] PATT_IRE_80  = 4'd8;
    localparam logic [PATT_W-1:0] PATT_IRE_90  = 4'd9;
    localparam logic [PATT_W-1:0] PATT_IRE_100 = 4'd10;
    localparam logic [PATT_W-1:0] PATT_RED     = 4'd11;
    localparam logic [PATT_W-1:0] PATT_GRN     = 4'd12;
    localparam logic [PATT_W-1:0] PATT_BLU     = 4'd13;
    localparam logic [PATT_W-1:0] PATT_WHT     = 4'd14;
    localparam logic [PATT_W-1:0] PATT_SMPTE   = 4'd15;

    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_NEXT = 2'd1,
        REQ_PREV = 2'd2
    } seq_req_t;

    typedef enum logic {
        S_MANUAL = 1'b0,
        S_AUTO   = 1'b1
    } seq_state_t;

    // Steps one position forward or back, wrapping within 0..last.
    function automatic logic [PATT_W-1:0] patt_step(
        input logic [PATT_W-1:0] cur,
        input logic              fwd,
        input logic [PATT_W-1:0] last
    );
        if (fwd) begin
            return (cur >= last) ? '0 : cur + 1'b1;
        end else begin
            return (cur == '0) ? last : cur - 1'b1;
        end
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Debouncer for an already-synchronised button level: the output follows the
// input only after DEBOUNCE_CYC consecutive samples that differ from it.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 33750
) (
    input  logic pclk,
    input  logic reset_n,
    input  logic sync_i,
    output logic stable_o
);

    localparam int unsigned    CNT_W    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sync_i == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = sync_i;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/vga_pattern_sequencer.sv
// Frame-synchronous pattern selector for the 240p test-pattern generator: manual
// next/prev plus auto-cycle. Define PATT_SEQ_DEBOUNCE_EN to debounce the buttons.
module vga_pattern_sequencer
    import vga_patt_pkg::*;
#(
    parameter int unsigned NUM_PATT     = 16,
    parameter int unsigned RESET_PATT   = 15,
    parameter int unsigned DWELL_W      = 8,
    parameter int unsigned DEBOUNCE_CYC = 33750
) (
    input  logic               pclk,
    input  logic               reset_n,
    input  logic               vblank,
    input  logic               btn_next,
    input  logic               btn_prev,
    input  logic               auto_en,
    input  logic [DWELL_W-1:0] dwell_frames,
    output logic [PATT_W-1:0]  patt_select,
    output logic               patt_changed,
    output logic               frame_tick
);

    localparam logic [PATT_W-1:0] PATT_LAST = PATT_W'(NUM_PATT - 1);
    localparam logic [PATT_W-1:0] PATT_RST  = PATT_W'(RESET_PATT);

    // ------------------------------------------------------------------
    // Button synchronisers, optional debounce, rising-edge detection
    // ------------------------------------------------------------------
    logic [1:0] next_sync_q, prev_sync_q;
    logic       next_clean, prev_clean;
    logic       next_lvl_q, prev_lvl_q;
    logic       next_press, prev_press;

`ifdef PATT_SEQ_DEBOUNCE_EN
    btn_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_deb_next (
        .pclk     (pclk),
        .reset_n  (reset_n),
        .sync_i   (next_sync_q[1]),
        .stable_o (next_clean)
    );

    btn_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_deb_prev (
        .pclk     (pclk),
        .reset_n  (reset_n),
        .sync_i   (prev_sync_q[1]),
        .stable_o (prev_clean)
    );
`else
    assign next_clean = next_sync_q[1];
    assign prev_clean = prev_sync_q[1];
`endif

    assign next_press = next_clean & ~next_lvl_q;
    assign prev_press = prev_clean & ~prev_lvl_q;

    // ------------------------------------------------------------------
    // Frame boundary
    // ------------------------------------------------------------------
    logic vblank_d_q;
    logic frame_edge;

    assign frame_edge = vblank & ~vblank_d_q;

    // ------------------------------------------------------------------
    // Request, dwell and mode state
    // ------------------------------------------------------------------
    seq_req_t           req_q, req_d;
    seq_state_t         state_q, state_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DWELL_W-1:0] dwell_limit;
    logic [PATT_W-1:0]  patt_q, patt_d;
    logic               patt_changed_q;
    logic               frame_tick_q;

    // A dwell of zero frames behaves like one frame.
    assign dwell_limit = (dwell_frames == '0) ? '0 : dwell_frames - 1'b1;

    // NOTE: every variable gets a default at the top of the block so no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        req_d   = req_q;
        patt_d  = patt_q;
        dwell_d = dwell_q;
        state_d = auto_en ? S_AUTO : S_MANUAL;

        if (frame_edge) begin
            if (req_q != REQ_NONE) begin
                patt_d  = patt_step(patt_q, req_q == REQ_NEXT, PATT_LAST);
                dwell_d = '0;
            end else if (state_q == S_AUTO && dwell_q >= dwell_limit) begin
                patt_d  = patt_step(patt_q, 1'b1, PATT_LAST);
                dwell_d = '0;
            end else if (state_q == S_AUTO && dwell_q != '1) begin
                dwell_d = dwell_q + 1'b1;
            end
            req_d = REQ_NONE;
        end

        // Presses coinciding with the edge land after the consume and wait a frame.
        if (next_press && prev_press) begin
            req_d = REQ_NONE;
        end else if (next_press) begin
            req_d = REQ_NEXT;
        end else if (prev_press) begin
            req_d = REQ_PREV;
        end

        if (state_d != state_q) begin
            dwell_d = '0;
        end
    end

    // NOTE: state is updated only with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            next_sync_q    <= '0;
            prev_sync_q    <= '0;
            next_lvl_q     <= 1'b0;
            prev_lvl_q     <= 1'b0;
            vblank_d_q     <= 1'b0;
            req_q          <= REQ_NONE;
            state_q        <= S_MANUAL;
            dwell_q        <= '0;
            patt_q         <= PATT_RST;
            patt_changed_q <= 1'b0;
            frame_tick_q   <= 1'b0;
        end else begin
            next_sync_q    <= {next_sync_q[0], btn_next};
            prev_sync_q    <= {prev_sync_q[0], btn_prev};
            next_lvl_q     <= next_clean;
            prev_lvl_q     <= prev_clean;
            vblank_d_q     <= vblank;
            req_q          <= req_d;
            state_q        <= state_d;
            dwell_q        <= dwell_d;
            patt_q         <= patt_d;
            patt_changed_q <= (patt_d != patt_q);
            frame_tick_q   <= frame_edge;
        end
    end

    assign patt_select  = patt_q;
    assign patt_changed = patt_changed_q;
    assign frame_tick   = frame_tick_q;

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// Directed bench for vga_pattern_sequencer: reset, manual wrap, cancel, auto
// dwell, manual-over-auto priority, async reset and (with the macro) debounce.
module tb_vga_pattern_sequencer;

`ifdef PATT_SEQ_DEBOUNCE_EN
    localparam int HOLD = 10;
`else
    localparam int HOLD = 3;
`endif

    logic       pclk         = 1'b0;
    logic       reset_n      = 1'b0;
    logic       vblank       = 1'b0;
    logic       btn_next     = 1'b0;
    logic       btn_prev     = 1'b0;
    logic       auto_en      = 1'b0;
    logic [7:0] dwell_frames = 8'd1;
    logic [3:0] patt_select;
    logic       patt_changed;
    logic       frame_tick;

    int total = 0;
    int bad   = 0;

    vga_pattern_sequencer #(
        .NUM_PATT     (16),
        .RESET_PATT   (15),
        .DWELL_W      (8),
        .DEBOUNCE_CYC (8)
    ) dut (
        .pclk         (pclk),
        .reset_n      (reset_n),
        .vblank       (vblank),
        .btn_next     (btn_next),
        .btn_prev     (btn_prev),
        .auto_en      (auto_en),
        .dwell_frames (dwell_frames),
        .patt_select  (patt_select),
        .patt_changed (patt_changed),
        .frame_tick   (frame_tick)
    );

    always #5 pclk = ~pclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge pclk);
    endtask

    // One frame: vblank rises, stays high 4 samples, low for 4 more.
    task automatic run_frame(output int ticks, output int chgs, output logic [3:0] patt);
        ticks = 0;
        chgs  = 0;
        patt  = 'x;
        @(negedge pclk);
        vblank = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge pclk);
            if (frame_tick === 1'b1) begin
                ticks++;
                patt = patt_select;
            end
            if (patt_changed === 1'b1) chgs++;
            if (i == 3) vblank = 1'b0;
        end
    endtask

    task automatic press(input logic nxt, input logic prv);
        @(negedge pclk);
        btn_next = nxt;
        btn_prev = prv;
        repeat (HOLD) @(negedge pclk);
        btn_next = 1'b0;
        btn_prev = 1'b0;
        idle(24);
    endtask

    task automatic test_reset;
        int t, c;
        logic [3:0] p;
        idle(3);
        total++;
        if (patt_select !== 4'd15) begin
            bad++;
            $display("FAIL reset_patt: got %0d, want 15", patt_select);
        end
        total++;
        if (patt_changed !== 1'b0 || frame_tick !== 1'b0) begin
            bad++;
            $display("FAIL reset_pulses: chg=%b tick=%b, want 0/0", patt_changed, frame_tick);
        end
        reset_n = 1'b1;
        idle(4);
        for (int f = 0; f < 2; f++) begin
            run_frame(t, c, p);
            total++;
            if (t !== 1 || c !== 0 || p !== 4'd15) begin
                bad++;
                $display("FAIL idle_frame%0d: ticks=%0d chg=%0d patt=%0d, want 1/0/15", f, t, c, p);
            end
        end
    endtask

    task automatic test_manual_wrap;
        int t, c;
        logic [3:0] p;
        press(1'b1, 1'b0);
        run_frame(t, c, p);
        total++;
        if (t !== 1 || c !== 1 || p !== 4'd0) begin
            bad++;
            $display("FAIL next_wrap: ticks=%0d chg=%0d patt=%0d, want 1/1/0", t, c, p);
        end
        press(1'b0, 1'b1);
        run_frame(t, c, p);
        total++;
        if (t !== 1 || c !== 1 || p !== 4'd15) begin
            bad++;
            $display("FAIL prev_wrap: ticks=%0d chg=%0d patt=%0d, want 1/1/15", t, c, p);
        end
    endtask

    task automatic test_cancel_overwrite;
        int t, c;
        logic [3:0] p;
        press(1'b1, 1'b1);
        run_frame(t, c, p);
        total++;
        if (t !== 1 || c !== 0 || p !== 4'd15) begin
            bad++;
            $display("FAIL cancel: ticks=%0d chg=%0d patt=%0d, want 1/0/15", t, c, p);
        end
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        run_frame(t, c, p);
        total++;
        if (t !== 1 || c !== 1 || p !== 4'd14) begin
            bad++;
            $display("FAIL overwrite: ticks=%0d chg=%0d patt=%0d, want 1/1/14", t, c, p);
        end
    endtask

    task automatic test_auto;
        int t, c;
        logic [3:0] p;
        // Walk 14 -> 15 -> 0 to start the dwell sequence at 0.
        for (int k = 0; k < 2; k++) begin
            press(1'b1, 1'b0);
            run_frame(t, c, p);
        end
        total++;
        if (p !== 4'd0) begin
            bad++;
            $display("FAIL auto_start: patt=%0d, want 0", p);
        end
        dwell_frames = 8'd3;
        auto_en      = 1'b1;
        idle(2);
        for (int i = 1; i <= 9; i++) begin
            run_frame(t, c, p);
            total++;
            if (t !== 1 || c !== ((i % 3 == 0) ? 1 : 0) || p !== 4'(i / 3)) begin
                bad++;
                $display("FAIL auto_dwell3 f%0d: ticks=%0d chg=%0d patt=%0d, want 1/%0d/%0d",
                         i, t, c, p, (i % 3 == 0) ? 1 : 0, i / 3);
            end
        end
        dwell_frames = 8'd0;
        for (int i = 1; i <= 3; i++) begin
            run_frame(t, c, p);
            total++;
            if (t !== 1 || c !== 1 || p !== 4'(3 + i)) begin
                bad++;
                $display("FAIL auto_dwell0 f%0d: ticks=%0d chg=%0d patt=%0d, want 1/1/%0d", i, t, c, p, 3 + i);
            end
        end
    endtask

    task automatic test_manual_beats_auto;
        int t, c;
        logic [3:0] p;
        logic [3:0] exp_p [2:9];
        int         exp_c [2:9];
        exp_p = '{4'd7, 4'd7, 4'd7, 4'd8, 4'd8, 4'd8, 4'd9, 4'd9};
        exp_c = '{1, 0, 0, 1, 0, 0, 1, 0};
        dwell_frames = 8'd3;
        run_frame(t, c, p);
        total++;
        if (t !== 1 || c !== 0 || p !== 4'd6) begin
            bad++;
            $display("FAIL mix f1: ticks=%0d chg=%0d patt=%0d, want 1/0/6", t, c, p);
        end
        press(1'b1, 1'b0);
        for (int i = 2; i <= 9; i++) begin
            run_frame(t, c, p);
            total++;
            if (t !== 1 || c !== exp_c[i] || p !== exp_p[i]) begin
                bad++;
                $display("FAIL mix f%0d: ticks=%0d chg=%0d patt=%0d, want 1/%0d/%0d",
                         i, t, c, p, exp_c[i], exp_p[i]);
            end
        end
        auto_en = 1'b0;
        idle(2);
        for (int i = 0; i < 4; i++) begin
            run_frame(t, c, p);
            total++;
            if (t !== 1 || c !== 0 || p !== 4'd9) begin
                bad++;
                $display("FAIL auto_off_hold f%0d: ticks=%0d chg=%0d patt=%0d, want 1/0/9", i, t, c, p);
            end
        end
    endtask

    task automatic test_async_reset;
        int t, c;
        logic [3:0] p;
        auto_en = 1'b1;
        idle(2);
        run_frame(t, c, p);
        total++;
        if (t !== 1 || c !== 0 || p !== 4'd9) begin
            bad++;
            $display("FAIL pre_reset: ticks=%0d chg=%0d patt=%0d, want 1/0/9", t, c, p);
        end
        press(1'b1, 1'b0);
        @(negedge pclk);
        reset_n = 1'b0;
        #1;
        total++;
        if (patt_select !== 4'd15 || patt_changed !== 1'b0 || frame_tick !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: patt=%0d chg=%b tick=%b, want 15/0/0", patt_select, patt_changed, frame_tick);
        end
        auto_en = 1'b0;
        idle(3);
        reset_n = 1'b1;
        idle(3);
        run_frame(t, c, p);
        total++;
        if (t !== 1 || c !== 0 || p !== 4'd15) begin
            bad++;
            $display("FAIL req_cleared: ticks=%0d chg=%0d patt=%0d, want 1/0/15", t, c, p);
        end
    endtask

`ifdef PATT_SEQ_DEBOUNCE_EN
    task automatic test_debounce;
        int t, c;
        logic [3:0] p;
        @(negedge pclk);
        btn_next = 1'b1;
        repeat (5) @(negedge pclk);
        btn_next = 1'b0;
        idle(24);
        run_frame(t, c, p);
        total++;
        if (t !== 1 || c !== 0 || p !== 4'd15) begin
            bad++;
            $display("FAIL glitch: ticks=%0d chg=%0d patt=%0d, want 1/0/15", t, c, p);
        end
        press(1'b1, 1'b0);
        run_frame(t, c, p);
        total++;
        if (t !== 1 || c !== 1 || p !== 4'd0) begin
            bad++;
            $display("FAIL debounced_press: ticks=%0d chg=%0d patt=%0d, want 1/1/0", t, c, p);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_manual_wrap();
        test_cancel_overwrite();
        test_auto();
        test_manual_beats_auto();
        test_async_reset();
`ifdef PATT_SEQ_DEBOUNCE_EN
        test_debounce();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
